// File: rtl/ysyx_22050019_mdu.sv
// ysyx_22050019_mdu: iterative RV64M multiply/divide unit.
//
// Accepts one M-extension operation through a valid/ready handshake, computes it over N
// cycles (N = XLEN for full-width ops, 32 for W ops), and holds the result until the
// consumer takes it. Multiply is MSB-first shift-add into a 2*XLEN accumulator. Divide is
// radix-2 restoring. Both work on operand magnitudes, and the result sign is applied on
// entry to DONE. Divide-by-zero, signed overflow and reserved op codes bypass CALC.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             abort the current operation (highest priority)
//   in_valid/in_ready request handshake; op, src1, src2, rd_i latched on acceptance
//   out_valid/out_ready result handshake; result and rd_o held while out_valid=1
//   busy              state is not IDLE
//
// Configuration macro: YSYX_22050019_FAST_MUL_EN. When it is defined, multiplies use a
// single-cycle combinational product and go directly from IDLE to DONE.
module ysyx_22050019_mdu #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_o,
    output logic            busy
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Applies the sign and selects the result. The multiply result is the
    // 2*XLEN product. The divide result has the remainder in the upper half
    // and the quotient in the lower half.
    function automatic logic [XLEN-1:0] finalize(input logic [3:0]        f_op,
                                                 input logic              f_neg,
                                                 input logic [2*XLEN-1:0] f_acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   val;
        prod = f_neg ? -f_acc : f_acc;
        if (f_op[2]) begin
            val = f_op[1] ? f_acc[2*XLEN-1:XLEN] : f_acc[XLEN-1:0];
            if (f_neg) val = -val;
        end else begin
            val = (f_op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        if (f_op[3]) val = sext32(val[31:0]);
        return val;
    endfunction

    // Decode and operand preparation for the incoming request.
    logic            in_w, in_rsvd, in_mul, in_div, s1_signed, s2_signed;
    logic [XLEN-1:0] op1, op2, mag1, mag2, min_val, special_val;
    logic            neg1, neg2, neg_in, div_zero, ovf;

    always_comb begin
        in_w      = op[3];
        in_rsvd   = op[3] && !op[2] && (op[1:0] != 2'b00);
        in_mul    = !op[2] && !in_rsvd;
        in_div    = op[2];
        // The MULH family is MUL/MULH s*s, MULHSU s*u and MULHU u*u. The divide family is unsigned when op[0]=1.
        s1_signed = in_mul ? (in_w || (op[1:0] != 2'b11)) : !op[0];
        s2_signed = in_mul ? (in_w || !op[1]) : !op[0];

        if (in_w) begin
            op1 = s1_signed ? sext32(src1[31:0]) : XLEN'(src1[31:0]);
            op2 = s2_signed ? sext32(src2[31:0]) : XLEN'(src2[31:0]);
        end else begin
            op1 = src1;
            op2 = src2;
        end

        neg1 = s1_signed && op1[XLEN-1];
        neg2 = s2_signed && op2[XLEN-1];
        mag1 = neg1 ? -op1 : op1;
        mag2 = neg2 ? -op2 : op2;
        // The remainder takes the dividend's sign. Other results are negative when the operand signs differ.
        neg_in = (in_div && op[1]) ? neg1 : (neg1 ^ neg2);

        min_val  = in_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = in_div && (op2 == '0);
        ovf      = in_div && !op[0] && (op1 == min_val) && (&op2);

        if (in_rsvd) begin
            special_val = '0;
        end else if (div_zero) begin
            special_val = op[1] ? op1 : '1;
        end else begin
            special_val = op[1] ? '0 : op1;
        end
        if (in_w) special_val = sext32(special_val[31:0]);
    end

    // One iteration of the multiplier or the divider.
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_new;
    logic              q_bit;

    always_comb begin
        rem_shift = {acc_q[2*XLEN-1:XLEN], a_q[cnt_q]};
        if (rem_shift >= {1'b0, b_q}) begin
            rem_new = XLEN'(rem_shift - {1'b0, b_q});
            q_bit   = 1'b1;
        end else begin
            rem_new = rem_shift[XLEN-1:0];
            q_bit   = 1'b0;
        end

        if (op_q[2]) begin
            acc_step = {rem_new, acc_q[XLEN-2:0], q_bit};
        end else begin
            acc_step = {acc_q[2*XLEN-2:0], 1'b0}
                     + (b_q[cnt_q] ? {{XLEN{1'b0}}, a_q} : '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_d     = rd_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = op;
                    neg_d = neg_in;
                    a_d   = mag1;
                    b_d   = mag2;
                    acc_d = '0;
                    rd_d  = rd_i;
                    cnt_d = in_w ? CntW'(31) : CntW'(XLEN - 1);
                    if (in_rsvd || div_zero || ovf) begin
                        state_d  = StDone;
                        result_d = special_val;
                    end
`ifdef YSYX_22050019_FAST_MUL_EN
                    else if (in_mul) begin
                        state_d  = StDone;
                        result_d = finalize(op, neg_in,
                                            {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2});
                    end
`endif
                    else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d  = StDone;
                    result_d = finalize(op_q, neg_q, acc_step);
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;
    assign rd_o      = rd_q;

endmodule

// File: tb/tb_ysyx_22050019_mdu.sv
// Self-checking bench for ysyx_22050019_mdu (XLEN=64): directed cases, flush/reset
// aborts and randomized operations against an arithmetic reference model.
module tb_ysyx_22050019_mdu;

    localparam int unsigned XLEN = 64;
`ifdef YSYX_22050019_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MULW_LAT = 1;
`else
    localparam int MUL_LAT  = 65;
    localparam int MULW_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [63:0] src1, src2, result;
    logic [4:0]  rd_i, rd_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_22050019_mdu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .rd_i      (rd_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_o      (rd_o),
        .busy      (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model computed directly from the RISC-V M-extension rules.
    function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [63:0] a,
                                              input logic [63:0] b);
        logic signed [127:0] wa, wb, p;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         ua32, ub32, r32;
        logic [63:0]         r;
        sa = a; sb = b;
        ua32 = a[31:0]; ub32 = b[31:0];
        sa32 = a[31:0]; sb32 = b[31:0];
        r = '0; r32 = '0; wa = '0; wb = '0; p = '0;
        case (o)
            4'd0: r = a * b;
            4'd1: begin wa = 128'(sa); wb = 128'(sb); p = wa * wb; r = p[127:64]; end
            4'd2: begin wa = 128'(sa); wb = {64'b0, b}; p = wa * wb; r = p[127:64]; end
            4'd3: begin wa = {64'b0, a}; wb = {64'b0, b}; p = wa * wb; r = p[127:64]; end
            4'd4: begin
                if (b == 0) r = '1;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                else r = sa / sb;
            end
            4'd5: begin if (b == 0) r = '1; else r = a / b; end
            4'd6: begin
                if (b == 0) r = a;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                else r = sa % sb;
            end
            4'd7: begin if (b == 0) r = a; else r = a % b; end
            4'd8, 4'd12, 4'd13, 4'd14, 4'd15: begin
                case (o)
                    4'd8: r32 = ua32 * ub32;
                    4'd12: begin
                        if (ub32 == 0) r32 = '1;
                        else if (ua32 == 32'h8000_0000 && ub32 == '1) r32 = ua32;
                        else r32 = sa32 / sb32;
                    end
                    4'd13: begin if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32; end
                    4'd14: begin
                        if (ub32 == 0) r32 = ua32;
                        else if (ua32 == 32'h8000_0000 && ub32 == '1) r32 = '0;
                        else r32 = sa32 % sb32;
                    end
                    default: begin if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32; end
                endcase
                r = {{32{r32[31]}}, r32};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] o, input logic [63:0] a,
                                   input logic [63:0] b);
        logic w, zero, ovf;
        w = o[3];
        if (o == 4'd9 || o == 4'd10 || o == 4'd11) return 1;
        if (!o[2]) return w ? MULW_LAT : MUL_LAT;
        zero = w ? (b[31:0] == 0) : (b == 0);
        ovf  = !o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (zero || ovf) return 1;
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return {32'($urandom), 32'h8000_0000};
            5: return {32'($urandom), 32'hFFFF_FFFF};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic do_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r, input logic [63:0] exp_res, input int lat_exp,
                         input int hold, input string tag);
        int lat;
        @(negedge clk);
        check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; src1 = a; src2 = b; rd_i = r;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0; src1 = ~a; src2 = ~b; rd_i = ~r;
        check({tag, ":busy"}, 64'(busy), 64'd1);
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ":latency"}, 64'(lat), 64'(lat_exp));
        check({tag, ":result"}, result, exp_res);
        check({tag, ":rd_o"}, 64'(rd_o), 64'(r));
        repeat (hold) begin
            @(negedge clk);
            check({tag, ":hold_result"}, result, exp_res);
            check({tag, ":hold_rd_o"}, 64'(rd_o), 64'(r));
            check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ":hold_out_valid"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":post_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ":post_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ":post_busy"}, 64'(busy), 64'd0);
    endtask

    logic [3:0] codes [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                               4'd12, 4'd13, 4'd14, 4'd15, 4'd10};

    initial begin
        int          seen;
        logic [3:0]  ro;
        logic [63:0] ra, rb;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; src1 = '0; src2 = '0; rd_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset:out_valid", 64'(out_valid), 64'd0);
        check("reset:result", result, 64'd0);
        check("reset:rd_o", 64'(rd_o), 64'd0);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:in_ready", 64'(in_ready), 64'd1);

        do_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB,
              MUL_LAT, 0, "mul");
        do_op(4'd3, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT, 0, "mulhu");
        do_op(4'd1, '1, '1, 5'd5, 64'd0, MUL_LAT, 0, "mulh");
        do_op(4'd5, 64'd5, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "divu_zero");
        do_op(4'd7, 64'd5, 64'd0, 5'd7, 64'd5, 1, 0, "remu_zero");
        do_op(4'd4, 64'h8000_0000_0000_0000, '1, 5'd8, 64'h8000_0000_0000_0000, 1, 0,
              "div_ovf");
        do_op(4'd6, 64'h8000_0000_0000_0000, '1, 5'd9, 64'd0, 1, 0, "rem_ovf");
        do_op(4'd12, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0,
              "divw");
        do_op(4'd14, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0,
              "remw");
        do_op(4'd9, 64'd123, 64'd45, 5'd12, 64'd0, 1, 0, "reserved");
        do_op(4'd7, 64'd100, 64'd7, 5'h1f, 64'd2, 65, 5, "hold");

        // Flush in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd4; src1 = 64'h0123_4567_89AB_CDEF; src2 = 64'd3; rd_i = 5'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("flush:busy_before", 64'(busy), 64'd1);
        flush = 1'b1; in_valid = 1'b1; op = 4'd5; src1 = 64'd5; src2 = 64'd0;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush:in_ready", 64'(in_ready), 64'd1);
        check("flush:out_valid", 64'(out_valid), 64'd0);
        check("flush:busy", 64'(busy), 64'd0);
        // A request arriving with flush in IDLE is ignored.
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle:busy", 64'(busy), 64'd0);
        check("flush_idle:out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush:no_out_valid", 64'(seen), 64'd0);

        // Reset in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd5; src1 = '1; src2 = 64'd3; rd_i = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst:out_valid", 64'(out_valid), 64'd0);
        check("rst:result", result, 64'd0);
        check("rst:rd_o", 64'(rd_o), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 40; i++) begin
            ro = codes[$urandom_range(0, 13)];
            ra = rand_operand();
            rb = rand_operand();
            do_op(ro, ra, rb, 5'($urandom), ref_model(ro, ra, rb), exp_lat(ro, ra, rb),
                  int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
